// File: rtl/interrupt_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : interrupt_sequencer_pkg
// Purpose  : Shared constants, state encoding and SP helper for interrupt entry/exit.
// Revision : 1.0
// ============================================================================
package interrupt_sequencer_pkg;

    localparam int unsigned c_DATA_W        = 16;
    localparam int unsigned c_CCR_W         = 3;
    localparam int unsigned c_DRAIN_CNT_W   = 8;
    localparam int unsigned c_DRAIN_CYCLES  = 3;
    localparam logic [15:0] c_INT_VECTOR    = 16'h0000;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DRAIN    = 4'd1,
        ST_PUSH_PC  = 4'd2,
        ST_PUSH_CCR = 4'd3,
        ST_VECTOR   = 4'd4,
        ST_ISR      = 4'd5,
        ST_POP_CCR  = 4'd6,
        ST_POP_PC   = 4'd7,
        ST_RESUME   = 4'd8
    } state_t;

    // Stack grows downward; wraps modulo 2^16 in both directions.
    function automatic logic [c_DATA_W-1:0] sp_next(input logic [c_DATA_W-1:0] sp,
                                                    input logic              pop);
        return pop ? (sp + 16'd1) : (sp - 16'd1);
    endfunction

endpackage : interrupt_sequencer_pkg
`default_nettype wire

// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : interrupt_sequencer_if
// Purpose   : Pipeline/memory/register-file signals seen by the interrupt sequencer.
// Revision  : 1.0
// ============================================================================
interface interrupt_sequencer_if;
    import interrupt_sequencer_pkg::*;

    logic                int_req;
    logic                rti_ex;
    logic [c_DATA_W-1:0] pc_in;
    logic [c_CCR_W-1:0]  ccr_in;
    logic [c_DATA_W-1:0] sp_in;
    logic [c_DATA_W-1:0] mem_rdata;

    logic                stall_fetch;
    logic                inject_nop;
    logic                mem_read;
    logic                mem_write;
    logic [c_DATA_W-1:0] mem_addr;
    logic [c_DATA_W-1:0] mem_wdata;
    logic                sp_write;
    logic [c_DATA_W-1:0] sp_wdata;
    logic                pc_load;
    logic [c_DATA_W-1:0] pc_wdata;
    logic                ccr_load;
    logic [c_CCR_W-1:0]  ccr_wdata;
    logic                in_isr;

    modport slave (
        input  int_req, rti_ex, pc_in, ccr_in, sp_in, mem_rdata,
        output stall_fetch, inject_nop, mem_read, mem_write, mem_addr, mem_wdata,
               sp_write, sp_wdata, pc_load, pc_wdata, ccr_load, ccr_wdata, in_isr
    );

    modport master (
        output int_req, rti_ex, pc_in, ccr_in, sp_in, mem_rdata,
        input  stall_fetch, inject_nop, mem_read, mem_write, mem_addr, mem_wdata,
               sp_write, sp_wdata, pc_load, pc_wdata, ccr_load, ccr_wdata, in_isr
    );

endinterface : interrupt_sequencer_if
`default_nettype wire

// File: rtl/interrupt_sequencer_var_reg.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_sequencer_var_reg
// Purpose  : Width-parameterised load-enable register (var_reg) with async reset.
// Revision : 1.0
// ============================================================================
module interrupt_sequencer_var_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : interrupt_sequencer_var_reg
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_sequencer
// Purpose  : Drains the pipeline, pushes PC/CCR, vectors to the ISR and restores on RTI.
// Revision : 1.0
// ============================================================================
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = c_DRAIN_CYCLES,
    parameter logic [15:0] INT_VECTOR   = c_INT_VECTOR
) (
    input  wire logic             clk,
    input  wire logic             reset,
    interrupt_sequencer_if.slave  bus
);

    localparam logic [c_DRAIN_CNT_W-1:0] c_DRAIN_LOAD = c_DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_DRAIN_CNT_W-1:0] r_drain_cnt;
    logic [c_DATA_W-1:0]      w_saved_pc;
    logic                     w_accept;
    logic [c_DATA_W-1:0]      w_sp_push;
    logic [c_DATA_W-1:0]      w_sp_pop;

    assign w_accept  = (r_state == ST_IDLE) && bus.int_req;
    assign w_sp_push = sp_next(bus.sp_in, 1'b0);
    assign w_sp_pop  = sp_next(bus.sp_in, 1'b1);

    interrupt_sequencer_var_reg #(
        .WIDTH (c_DATA_W)
    ) u_saved_pc (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_accept),
        .i_d  (bus.pc_in),
        .o_q  (w_saved_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_drain_cnt <= c_DRAIN_LOAD;
            end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - 1'b1;
            end
        end
    end

    // IDLE drives every output to zero, so an async reset clears them at once.
    always_comb begin
        w_state_next    = r_state;
        bus.stall_fetch = 1'b0;
        bus.inject_nop  = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.sp_write    = 1'b0;
        bus.sp_wdata    = '0;
        bus.pc_load     = 1'b0;
        bus.pc_wdata    = '0;
        bus.ccr_load    = 1'b0;
        bus.ccr_wdata   = '0;
        bus.in_isr      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.int_req) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                bus.stall_fetch = 1'b1;
                bus.inject_nop  = 1'b1;
                if (r_drain_cnt == '0) w_state_next = ST_PUSH_PC;
            end
            ST_PUSH_PC: begin
                bus.stall_fetch = 1'b1;
                bus.inject_nop  = 1'b1;
                bus.mem_write   = 1'b1;
                bus.mem_addr    = bus.sp_in;
                bus.mem_wdata   = w_saved_pc;
                bus.sp_write    = 1'b1;
                bus.sp_wdata    = w_sp_push;
                w_state_next    = ST_PUSH_CCR;
            end
            ST_PUSH_CCR: begin
                bus.stall_fetch = 1'b1;
                bus.inject_nop  = 1'b1;
                bus.mem_write   = 1'b1;
                bus.mem_addr    = bus.sp_in;
                bus.mem_wdata   = {13'b0, bus.ccr_in};
                bus.sp_write    = 1'b1;
                bus.sp_wdata    = w_sp_push;
                w_state_next    = ST_VECTOR;
            end
            ST_VECTOR: begin
                bus.stall_fetch = 1'b1;
                bus.inject_nop  = 1'b1;
                bus.pc_load     = 1'b1;
                bus.pc_wdata    = INT_VECTOR;
                w_state_next    = ST_ISR;
            end
            ST_ISR: begin
                bus.in_isr = 1'b1;
                if (bus.rti_ex) w_state_next = ST_POP_CCR;
            end
            ST_POP_CCR: begin
                bus.stall_fetch = 1'b1;
                bus.inject_nop  = 1'b1;
                bus.mem_read    = 1'b1;
                bus.mem_addr    = w_sp_pop;
                bus.sp_write    = 1'b1;
                bus.sp_wdata    = w_sp_pop;
                w_state_next    = ST_POP_PC;
            end
            ST_POP_PC: begin
                bus.stall_fetch = 1'b1;
                bus.inject_nop  = 1'b1;
                bus.ccr_load    = 1'b1;
                bus.ccr_wdata   = bus.mem_rdata[2:0];
                bus.mem_read    = 1'b1;
                bus.mem_addr    = w_sp_pop;
                bus.sp_write    = 1'b1;
                bus.sp_wdata    = w_sp_pop;
                w_state_next    = ST_RESUME;
            end
            ST_RESUME: begin
                bus.stall_fetch = 1'b1;
                bus.inject_nop  = 1'b1;
                bus.pc_load     = 1'b1;
                bus.pc_wdata    = bus.mem_rdata;
                w_state_next    = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule : interrupt_sequencer
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_sequencer
// Purpose  : Directed self-checking bench for interrupt entry, exit, wrap and reset.
// Revision : 1.0
// ============================================================================
module tb_interrupt_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    interrupt_sequencer_if bus ();

    interrupt_sequencer #(
        .DRAIN_CYCLES (3),
        .INT_VECTOR   (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [74:0] all_out;
    assign all_out = {bus.stall_fetch, bus.inject_nop, bus.mem_read, bus.mem_write,
                      bus.mem_addr, bus.mem_wdata, bus.sp_write, bus.sp_wdata,
                      bus.pc_load, bus.pc_wdata, bus.ccr_load, bus.ccr_wdata, bus.in_isr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_checks++;
        if (all_out !== 75'd0) $display("FAIL reset_async outputs=%h expected 0", all_out);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (all_out !== 75'd0) $display("FAIL reset_held outputs=%h expected 0", all_out);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        step();
        n_checks++;
        if (all_out !== 75'd0) $display("FAIL reset_idle outputs=%h expected 0", all_out);
        else n_pass++;
    endtask

    task automatic test_entry();
        bus.pc_in   = 16'h0040;
        bus.sp_in   = 16'h0FFF;
        bus.ccr_in  = 3'b101;
        bus.int_req = 1'b1;
        step();
        bus.int_req = 1'b0;
        bus.pc_in   = 16'h1234;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus.stall_fetch, bus.inject_nop, bus.mem_write, bus.sp_write, bus.in_isr} !== 5'b11000)
                $display("FAIL drain_cycle%0d got=%b expected 11000", i,
                         {bus.stall_fetch, bus.inject_nop, bus.mem_write, bus.sp_write, bus.in_isr});
            else n_pass++;
            if (i < 2) step();
        end
        step();
        n_checks++;
        if ({bus.mem_write, bus.mem_read, bus.sp_write, bus.stall_fetch, bus.mem_addr, bus.mem_wdata, bus.sp_wdata}
            !== {4'b1011, 16'h0FFF, 16'h0040, 16'h0FFE})
            $display("FAIL push_pc wr=%b addr=%h wdata=%h sp_wdata=%h expected 1 0FFF 0040 0FFE",
                     bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.sp_wdata);
        else n_pass++;
        step();
        bus.sp_in = 16'h0FFE;
        #1;
        n_checks++;
        if ({bus.mem_write, bus.sp_write, bus.mem_addr, bus.mem_wdata, bus.sp_wdata}
            !== {2'b11, 16'h0FFE, 16'h0005, 16'h0FFD})
            $display("FAIL push_ccr wr=%b addr=%h wdata=%h sp_wdata=%h expected 1 0FFE 0005 0FFD",
                     bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.sp_wdata);
        else n_pass++;
        step();
        bus.sp_in = 16'h0FFD;
        #1;
        n_checks++;
        if ({bus.pc_load, bus.pc_wdata, bus.mem_write, bus.sp_write, bus.stall_fetch}
            !== {1'b1, 16'h0000, 3'b001})
            $display("FAIL vector pc_load=%b pc_wdata=%h wr=%b spw=%b stall=%b expected 1 0000 0 0 1",
                     bus.pc_load, bus.pc_wdata, bus.mem_write, bus.sp_write, bus.stall_fetch);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({bus.in_isr, bus.stall_fetch, bus.inject_nop, bus.pc_load} !== 4'b1000)
                $display("FAIL isr_cycle%0d got=%b expected 1000", i,
                         {bus.in_isr, bus.stall_fetch, bus.inject_nop, bus.pc_load});
            else n_pass++;
        end
    endtask

    task automatic test_exit();
        bus.sp_in  = 16'h0FFD;
        bus.rti_ex = 1'b1;
        step();
        bus.rti_ex = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_read, bus.mem_write, bus.sp_write, bus.stall_fetch, bus.inject_nop, bus.in_isr,
             bus.ccr_load, bus.mem_addr, bus.sp_wdata} !== {7'b1011100, 16'h0FFE, 16'h0FFE})
            $display("FAIL pop_ccr rd=%b addr=%h sp_wdata=%h isr=%b expected 1 0FFE 0FFE 0",
                     bus.mem_read, bus.mem_addr, bus.sp_wdata, bus.in_isr);
        else n_pass++;
        step();
        bus.sp_in     = 16'h0FFE;
        bus.mem_rdata = 16'h0005;
        #1;
        n_checks++;
        if ({bus.ccr_load, bus.ccr_wdata, bus.mem_read, bus.sp_write, bus.mem_addr, bus.sp_wdata}
            !== {1'b1, 3'b101, 2'b11, 16'h0FFF, 16'h0FFF})
            $display("FAIL pop_pc ccr_load=%b ccr=%b addr=%h sp_wdata=%h expected 1 101 0FFF 0FFF",
                     bus.ccr_load, bus.ccr_wdata, bus.mem_addr, bus.sp_wdata);
        else n_pass++;
        step();
        bus.sp_in     = 16'h0FFF;
        bus.mem_rdata = 16'h0040;
        #1;
        n_checks++;
        if ({bus.pc_load, bus.pc_wdata, bus.mem_read, bus.sp_write, bus.ccr_load, bus.stall_fetch}
            !== {1'b1, 16'h0040, 4'b0001})
            $display("FAIL resume pc_load=%b pc_wdata=%h rd=%b spw=%b expected 1 0040 0 0",
                     bus.pc_load, bus.pc_wdata, bus.mem_read, bus.sp_write);
        else n_pass++;
        step();
        bus.mem_rdata = 16'h0000;
        #1;
        n_checks++;
        if (all_out !== 75'd0) $display("FAIL exit_idle outputs=%h expected 0", all_out);
        else n_pass++;
    endtask

    task automatic test_no_nesting();
        bus.pc_in   = 16'h0100;
        bus.sp_in   = 16'h0FFF;
        bus.ccr_in  = 3'b010;
        bus.int_req = 1'b1;
        repeat (7) step();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus.in_isr, bus.stall_fetch} !== 2'b10)
                $display("FAIL nest_isr%0d isr=%b stall=%b expected 1 0", i, bus.in_isr, bus.stall_fetch);
            else n_pass++;
            step();
        end
        bus.rti_ex = 1'b1;
        step();
        bus.rti_ex = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.pc_load !== 1'b1) $display("FAIL nest_resume pc_load=%b expected 1", bus.pc_load);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.stall_fetch, bus.in_isr, bus.mem_write} !== 3'b000)
            $display("FAIL nest_idle_gap got=%b expected 000", {bus.stall_fetch, bus.in_isr, bus.mem_write});
        else n_pass++;
        step();
        bus.int_req = 1'b0;
        n_checks++;
        if ({bus.stall_fetch, bus.inject_nop} !== 2'b11)
            $display("FAIL nest_reaccept got=%b expected 11", {bus.stall_fetch, bus.inject_nop});
        else n_pass++;
    endtask

    task automatic test_sp_wrap();
        bus.pc_in = 16'h0200;
        bus.sp_in = 16'h0000;
        step();
        step();
        step();
        n_checks++;
        if ({bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.sp_wdata} !== {1'b1, 16'h0000, 16'h0100, 16'hFFFF})
            $display("FAIL wrap_push wr=%b addr=%h wdata=%h sp_wdata=%h expected 1 0000 0100 FFFF",
                     bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.sp_wdata);
        else n_pass++;
        step();
        bus.sp_in = 16'hFFFF;
        step();
        step();
        bus.rti_ex = 1'b1;
        step();
        bus.rti_ex = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_read, bus.mem_addr, bus.sp_wdata} !== {1'b1, 16'h0000, 16'h0000})
            $display("FAIL wrap_pop rd=%b addr=%h sp_wdata=%h expected 1 0000 0000",
                     bus.mem_read, bus.mem_addr, bus.sp_wdata);
        else n_pass++;
        step();
        bus.sp_in     = 16'h0000;
        bus.mem_rdata = 16'h0002;
        step();
        bus.mem_rdata = 16'h0100;
        step();
        bus.mem_rdata = 16'h0000;
    endtask

    task automatic test_reset_mid();
        bus.pc_in   = 16'h0300;
        bus.sp_in   = 16'h0800;
        bus.ccr_in  = 3'b111;
        bus.int_req = 1'b1;
        step();
        bus.int_req = 1'b0;
        repeat (4) step();
        bus.sp_in = 16'h07FF;
        #1;
        n_checks++;
        if ({bus.mem_write, bus.mem_wdata} !== {1'b1, 16'h0007})
            $display("FAIL mid_push_ccr wr=%b wdata=%h expected 1 0007", bus.mem_write, bus.mem_wdata);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (all_out !== 75'd0) $display("FAIL mid_reset_async outputs=%h expected 0", all_out);
        else n_pass++;
        step();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (all_out !== 75'd0) $display("FAIL mid_reset_idle%0d outputs=%h expected 0", i, all_out);
            else n_pass++;
        end
    endtask

    task automatic test_rti_idle();
        bus.rti_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (all_out !== 75'd0) $display("FAIL rti_idle%0d outputs=%h expected 0", i, all_out);
            else n_pass++;
        end
        bus.rti_ex = 1'b0;
        step();
        n_checks++;
        if (all_out !== 75'd0) $display("FAIL rti_idle_after outputs=%h expected 0", all_out);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        bus.int_req   = 1'b0;
        bus.rti_ex    = 1'b0;
        bus.pc_in     = 16'h0000;
        bus.ccr_in    = 3'b000;
        bus.sp_in     = 16'h0000;
        bus.mem_rdata = 16'h0000;

        test_reset();
        test_entry();
        test_exit();
        test_no_nesting();
        test_sp_wrap();
        test_reset_mid();
        test_rti_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_interrupt_sequencer
`default_nettype wire
